// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the pwm_multi block: counting modes, counter
// direction encoding and the packed compare-bus slicing helpers.
package pwm_pkg;

   localparam int MODE_EDGE   = 0;
   localparam int MODE_CENTER = 1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Compare values carry one extra bit so a channel can request 100% duty.
   function automatic int cmp_width(input int width);
      return width + 1;
   endfunction

   function automatic int ch_lsb(input int ch, input int width);
      return ch * cmp_width(width);
   endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Single-channel dead-band generator: a rising edge on either output waits until the
// input has held its new level for DEADTIME further cycles; falling edges pass straight through.
module pwm_deadtime #(
   parameter int DEADTIME = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_pwm,
   output logic o_pwm,
   output logic o_pwm_n
);

   localparam int RW = $clog2(DEADTIME + 2);
   localparam logic [RW-1:0] RUN_MAX = RW'(DEADTIME + 1);

   logic          lvl_q;
   logic [RW-1:0] run_q;
   logic [RW-1:0] run_d;

   // run_d = consecutive cycles the input has held its current level, this cycle included.
   always_comb begin
      run_d = RW'(1);
      if (i_pwm == lvl_q) begin
         run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lvl_q <= 1'b0;
         run_q <= '0;
      end else begin
         lvl_q <= i_pwm;
         run_q <= run_d;
      end
   end

   assign o_pwm   =  i_pwm && (run_d == RUN_MAX);
   assign o_pwm_n = !i_pwm && (run_d == RUN_MAX);

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter, double-buffered TOP/compare registers.
// Define PWM_DEADTIME_EN to route every channel through a pwm_deadtime dead-band generator.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int               WIDTH          = 8,
   parameter int               NUM_CH         = 4,
   parameter int               CENTER_ALIGNED = MODE_EDGE,
   parameter logic [WIDTH-1:0] TOP_RESET      = {WIDTH{1'b1}},
   parameter int               DEADTIME       = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_enable,
   input  logic [WIDTH-1:0]               i_top,
   input  logic                           i_top_valid,
   input  logic [NUM_CH*(WIDTH+1)-1:0]    i_compare,
   input  logic [NUM_CH-1:0]              i_compare_valid,
   output logic [NUM_CH-1:0]              o_pwm,
   output logic [NUM_CH-1:0]              o_pwm_n,
   output logic                           o_period_start
);

   localparam int CW = cmp_width(WIDTH);

   // Counter state is kept in one struct so checkers can bind to direction and count together.
   typedef struct packed {
      dir_e             dir;
      logic [WIDTH-1:0] cnt;
   } ctr_state_t;

   // Write strobes have no ready: a valid is accepted on the clock edge it is high,
   // and the latest accepted value wins until the next load of the active registers.
   ctr_state_t        state_q, state_d;
   logic [WIDTH-1:0]  top_act, top_sh, top_nxt;
   logic [CW-1:0]     cmp_act [NUM_CH];
   logic [CW-1:0]     cmp_sh  [NUM_CH];
   logic [CW-1:0]     cmp_nxt [NUM_CH];
   logic              boundary;
   logic              load;
   logic [NUM_CH-1:0] raw;
   logic [NUM_CH-1:0] pwm_q;
   logic              period_start_q;

   assign load = boundary | ~i_enable;

   // *_nxt is the shadow value after this cycle's strobe, which also makes boundary writes bypass.
   always_comb begin
      top_nxt = i_top_valid ? i_top : top_sh;
      for (int k = 0; k < NUM_CH; k++) begin
         cmp_nxt[k] = i_compare_valid[k] ? i_compare[ch_lsb(k, WIDTH) +: CW] : cmp_sh[k];
         raw[k]     = ({1'b0, state_q.cnt} < cmp_act[k]);
      end
   end

   always_comb begin
      state_d = state_q;
      if (CENTER_ALIGNED == MODE_CENTER) begin
         boundary = (top_act == '0) || (state_q.dir == DIR_DOWN && state_q.cnt == '0);
      end else begin
         boundary = (state_q.cnt == top_act);
      end
      if (!i_enable) begin
         state_d.cnt = '0;
         state_d.dir = DIR_UP;
      end else if (CENTER_ALIGNED == MODE_CENTER) begin
         // The down-count zero doubles as the next period's first cycle, so it restarts at 1.
         if (boundary) begin
            state_d.dir = DIR_UP;
            state_d.cnt = (top_nxt == '0) ? '0 : WIDTH'(1);
         end else if (state_q.dir == DIR_UP && state_q.cnt != top_act) begin
            state_d.cnt = state_q.cnt + WIDTH'(1);
         end else begin
            state_d.dir = DIR_DOWN;
            state_d.cnt = state_q.cnt - WIDTH'(1);
         end
      end else begin
         state_d.cnt = boundary ? '0 : state_q.cnt + WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q.dir    <= DIR_UP;
         state_q.cnt    <= '0;
         top_act        <= TOP_RESET;
         top_sh         <= TOP_RESET;
         pwm_q          <= '0;
         period_start_q <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            cmp_act[k] <= '0;
            cmp_sh[k]  <= '0;
         end
      end else begin
         state_q        <= state_d;
         top_sh         <= top_nxt;
         pwm_q          <= i_enable ? raw : '0;
         period_start_q <= i_enable & boundary;
         if (load) begin
            top_act <= top_nxt;
         end
         for (int k = 0; k < NUM_CH; k++) begin
            cmp_sh[k] <= cmp_nxt[k];
            if (load) begin
               cmp_act[k] <= cmp_nxt[k];
            end
         end
      end
   end

   assign o_period_start = period_start_q;

`ifdef PWM_DEADTIME_EN
   for (genvar k = 0; k < NUM_CH; k++) begin : g_dt
      pwm_deadtime #(
         .DEADTIME(DEADTIME)
      ) u_dt (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_pwm   (pwm_q[k]),
         .o_pwm   (o_pwm[k]),
         .o_pwm_n (o_pwm_n[k])
      );
   end
`else
   logic dt_unused;
   assign dt_unused = (DEADTIME != 0);
   assign o_pwm     = pwm_q;
   assign o_pwm_n   = ~pwm_q;
`endif

endmodule
